gen_step_scheduler: RTL and testbench
=====================================

GEN_STEP_SCHEDULER -- requirements
Module: gen_step_scheduler

Interface
REQ-001 SHALL have parameter GEN_W, default 16, width of the generation counter.
REQ-002 SHALL have port i_clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_run  input  1  level; 1 = free-running generation stepping.
REQ-005 SHALL have port i_step  input  1  one-cycle pulse; request a single generation.
REQ-006 SHALL have port i_period  input  32  minimum o_start-to-o_start spacing P in i_clk cycles.
REQ-007 SHALL have port i_done  input  1  one-cycle pulse from the update engine; generation finished.
REQ-008 SHALL have port i_clear  input  1  pulse; clears overrun status.
REQ-009 SHALL have port o_start  output  1  one-cycle pulse; engine begins a generation.
REQ-010 SHALL have port o_busy  output  1  high while a generation is in flight.
REQ-011 SHALL have port o_gen_count  output  GEN_W  completed generations, wrapping.
REQ-012 SHALL have port o_overrun  output  1  sticky; engine missed the requested rate.
REQ-013 SHALL have port o_overrun_cnt  output  8  late generations, saturating at 255.

Function
REQ-014 SHALL implement FSM states IDLE, START, RUN and WAIT; all outputs registered.
REQ-015 SHALL assert o_start for exactly the one cycle spent in START; START always goes to RUN next.
REQ-016 SHALL latch Ps = max(i_period,1) in START; i_period changes take effect at the next START only.
REQ-017 SHALL clear the 32-bit cycle counter cnt to 0 in START and increment it every later cycle, saturating at 0xFFFFFFFF.
REQ-018 SHALL transition IDLE->START when i_run=1 or i_step=1; i_step is ignored in all other states.
REQ-019 SHALL transition RUN->WAIT on i_done; i_done outside RUN is ignored.
REQ-020 SHALL increment o_gen_count (mod 2^GEN_W) on each accepted i_done.
REQ-021 SHALL transition WAIT->START when i_run=1 and cnt+1 >= Ps; WAIT->IDLE when i_run=0.
REQ-022 SHALL give start-to-start spacing max(Ps, L+2), where L = cycles from o_start to i_done (L>=1).
REQ-023 SHALL never abort RUN on i_run deassertion; the in-flight generation completes, then WAIT->IDLE.
REQ-024 SHALL drive o_busy=1 exactly in START and RUN.
REQ-025 SHALL give i_reset priority over i_clear, and i_clear priority over a same-cycle overrun set.

Reset
REQ-026 SHALL on i_reset set the state to IDLE, cnt=0, Ps=1 and o_start, o_busy, o_gen_count, o_overrun and o_overrun_cnt to 0, including mid-RUN, with no further o_start.
REQ-027 SHALL produce no o_start in the cycle that i_reset is high or in the cycle after it.

Configuration
REQ-028 SHALL, with GEN_SCHED_OVERRUN_EN defined, in RUN with i_run=1 and cnt+1 == Ps and no same-cycle i_done, set o_overrun and increment o_overrun_cnt once per generation.
REQ-029 SHALL, without GEN_SCHED_OVERRUN_EN, tie o_overrun and o_overrun_cnt to 0, ignore i_clear and omit the overrun logic.

Verification
REQ-030 SHALL cover free-run: i_period=10, i_run=1, i_done 3 cycles after each o_start -> o_start every 10 cycles, o_gen_count 0,1,2,...
REQ-031 SHALL cover slow engine: i_period=4, L=7 -> o_start every 9 cycles; with GEN_SCHED_OVERRUN_EN, o_overrun=1 and o_overrun_cnt +1 per generation.
REQ-032 SHALL cover single step: i_run=0, i_step pulse in IDLE -> one o_start, then IDLE after i_done; i_step during RUN -> ignored.
REQ-033 SHALL cover stop mid-generation: i_run drops in RUN -> no new o_start, i_done accepted, o_gen_count +1, final state IDLE, o_busy=0.
REQ-034 SHALL cover reset mid-RUN and wrap: i_reset in RUN -> all outputs 0, no o_start next cycle; GEN_W=4 with 16 generations -> o_gen_count wraps to 0.
REQ-035 SHALL cover period edge: i_period=0 and i_period=1 with L=1 -> o_start every 3 cycles; i_period changed mid-WAIT -> old Ps is used until the next START.

Source files
------------

// File: rtl/gen_step_scheduler.sv
// gen_step_scheduler: paces an external generation-update engine.
// Issues one-cycle o_start pulses, either free-running at a minimum spacing of
// max(i_period,1) cycles or single-stepped via i_step. Each in-flight generation
// is closed by i_done, and completed generations are counted.
// Optional feature macro: GEN_SCHED_OVERRUN_EN. When it is defined, the block
// flags generations that miss the requested rate (sticky o_overrun plus a
// saturating o_overrun_cnt, cleared by i_clear). Without it, both outputs are
// tied to zero.
module gen_step_scheduler #(
  parameter int unsigned GEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_step,
  input  logic [31:0]      i_period,
  input  logic             i_done,
  input  logic             i_clear,
  output logic             o_start,
  output logic             o_busy,
  output logic [GEN_W-1:0] o_gen_count,
  output logic             o_overrun,
  output logic [7:0]       o_overrun_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      ps_q, ps_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_acc;
  logic [32:0]      cnt_inc;

  // cnt+1 is kept 33 bits wide so the compare against Ps cannot wrap at saturation
  assign cnt_inc = {1'b0, cnt_q} + 33'd1;

  // Next-state decode; i_step only matters in IDLE, i_done only in RUN
  always_comb begin
    state_d  = state_q;
    done_acc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_run || i_step) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (i_done) begin
          state_d  = S_WAIT;
          done_acc = 1'b1;
        end
      end
      S_WAIT: begin
        if (!i_run) begin
          state_d = S_IDLE;
        end else if (cnt_inc >= {1'b0, ps_q}) begin
          state_d = S_START;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: cycle counter, latched period, generation count, registered outputs
  always_comb begin
    // cnt reads 0 during the START cycle itself, so cnt == cycles since o_start
    if (state_d == S_START) begin
      cnt_d = '0;
    end else if (cnt_inc[32]) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_inc[31:0];
    end

    // Period is sampled only while in START; later edits wait for the next START
    ps_d = ps_q;
    if (state_q == S_START) begin
      ps_d = (i_period == '0) ? 32'd1 : i_period;
    end

    gen_d   = gen_q + GEN_W'(done_acc);
    start_d = (state_d == S_START);
    busy_d  = (state_d == S_START) || (state_d == S_RUN);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ps_q    <= 32'd1;
      gen_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      gen_q   <= gen_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign o_start     = start_q;
  assign o_busy      = busy_q;
  assign o_gen_count = gen_q;

`ifdef GEN_SCHED_OVERRUN_EN
  logic       ovr_q, ovr_d;
  logic [7:0] ovr_cnt_q, ovr_cnt_d;
  logic       ovr_set;

  // Late when the period boundary passes while still in RUN; cnt hits Ps-1 only once per generation
  always_comb begin
    ovr_set   = (state_q == S_RUN) && i_run && !i_done && (cnt_inc == {1'b0, ps_q});
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    if (i_clear) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
    end else if (ovr_set) begin
      ovr_d = 1'b1;
      if (ovr_cnt_q != '1) begin
        ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
    end
  end

  // Overrun status registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign o_overrun     = ovr_q;
  assign o_overrun_cnt = ovr_cnt_q;
`else
  logic unused_clear;
  assign unused_clear  = i_clear;
  assign o_overrun     = 1'b0;
  assign o_overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_gen_step_scheduler.sv
// Directed testbench for gen_step_scheduler (GEN_W=4 so the counter wraps).
// A small engine model answers each o_start with i_done after eng_lat cycles;
// o_start cycles and the generation count seen at each start are recorded.
module tb_gen_step_scheduler;

`ifdef GEN_SCHED_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset, i_run, i_step, i_done, i_clear;
  logic [31:0] i_period;
  logic        o_start, o_busy, o_overrun;
  logic [3:0]  o_gen_count;
  logic [7:0]  o_overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int eng_lat  = 3;
  int due      = -1;
  int starts[$];
  int gens[$];

  gen_step_scheduler #(.GEN_W(4)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_run        (i_run),
    .i_step       (i_step),
    .i_period     (i_period),
    .i_done       (i_done),
    .i_clear      (i_clear),
    .o_start      (o_start),
    .o_busy       (o_busy),
    .o_gen_count  (o_gen_count),
    .o_overrun    (o_overrun),
    .o_overrun_cnt(o_overrun_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Engine model and start recorder, evaluated mid-cycle
  initial begin
    i_done = 1'b0;
    forever begin
      @(negedge i_clk);
      i_done = (cyc == due);
      if (o_start) begin
        due = cyc + eng_lat;
        starts.push_back(cyc);
        gens.push_back(int'(o_gen_count));
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic clear_log();
    starts.delete();
    gens.delete();
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int b = 0;
    while (starts.size() < n && b < budget) begin
      tick();
      b++;
    end
    check_eq({tag, "_nstart"}, starts.size(), n);
  endtask

  task automatic check_spacing(input string tag, input int exp);
    for (int i = 1; i < starts.size(); i++)
      check_eq($sformatf("%s_gap%0d", tag, i), starts[i] - starts[i-1], exp);
  endtask

  task automatic drain(input string tag, input int exp_gen);
    clear_log();
    repeat (30) tick();
    check_eq({tag, "_nostart"}, starts.size(), 0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_gen"}, o_gen_count, exp_gen);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_run = 1'b0; i_step = 1'b0; i_clear = 1'b0; i_period = 32'd10;
    repeat (2) tick();
    check_eq("rst_start", o_start, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_gen", o_gen_count, 0);
    check_eq("rst_ovr", o_overrun, 0);
    check_eq("rst_ovrcnt", o_overrun_cnt, 0);
    i_reset = 1'b0;
    tick();

    // Free run, P=10, L=3; stop during the 4th generation
    clear_log();
    eng_lat = 3; i_period = 32'd10; i_run = 1'b1;
    wait_starts("free", 4, 60);
    i_run = 1'b0;
    check_spacing("free", 10);
    for (int i = 0; i < gens.size(); i++)
      check_eq($sformatf("free_gen%0d", i), gens[i], i);
    check_eq("free_busy", o_busy, 1);
    drain("free_stop", 4);

    // Slow engine, P=4, L=7 -> spacing L+2
    clear_log();
    eng_lat = 7; i_period = 32'd4; i_run = 1'b1;
    wait_starts("slow", 4, 60);
    i_run = 1'b0;
    check_spacing("slow", 9);
    check_eq("slow_ovrcnt_mid", o_overrun_cnt, OVR ? 3 : 0);
    drain("slow_stop", 8);
    check_eq("slow_ovr", o_overrun, OVR ? 1 : 0);
    check_eq("slow_ovrcnt", o_overrun_cnt, OVR ? 3 : 0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    tick();
    check_eq("clr_ovr", o_overrun, 0);
    check_eq("clr_ovrcnt", o_overrun_cnt, 0);

    // Single step; a second i_step during RUN must be ignored
    clear_log();
    eng_lat = 5; i_step = 1'b1;
    tick();
    i_step = 1'b0;
    wait_starts("step", 1, 10);
    repeat (2) tick();
    check_eq("step_busy", o_busy, 1);
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    drain("step", 9);

    // i_period=0 and 1 with L=1 -> spacing 3
    clear_log();
    eng_lat = 1; i_period = 32'd0; i_run = 1'b1;
    wait_starts("p0", 4, 40);
    i_run = 1'b0;
    check_spacing("p0", 3);
    drain("p0", 13);
    clear_log();
    i_period = 32'd1; i_run = 1'b1;
    wait_starts("p1", 3, 40);
    i_run = 1'b0;
    check_spacing("p1", 3);
    drain("p1_wrap", 0);

    // Period changed in WAIT: old Ps (8) for this gap, new Ps (3) -> L+2=4 next
    clear_log();
    eng_lat = 2; i_period = 32'd8; i_run = 1'b1;
    wait_starts("pchg_first", 1, 10);
    repeat (4) tick();
    i_period = 32'd3;
    wait_starts("pchg", 3, 40);
    i_run = 1'b0;
    check_eq("pchg_gap_old", starts[1] - starts[0], 8);
    check_eq("pchg_gap_new", starts[2] - starts[1], 4);
    drain("pchg", 3);

    // Reset mid-RUN
    clear_log();
    eng_lat = 6; i_period = 32'd10; i_run = 1'b1;
    wait_starts("mrst", 1, 10);
    repeat (2) tick();
    check_eq("mrst_busy_pre", o_busy, 1);
    i_reset = 1'b1; i_run = 1'b0;
    tick();
    i_reset = 1'b0;
    check_eq("mrst_start", o_start, 0);
    check_eq("mrst_busy", o_busy, 0);
    check_eq("mrst_gen", o_gen_count, 0);
    check_eq("mrst_ovr", o_overrun, 0);
    drain("mrst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
